field_rom_scheduler: RTL and testbench

Time-slot scheduler that shares the single-port 160x120x4-bit field ROM between the VGA display path and a game-logic query port. Display fetches get a guaranteed slot once per 4-pixel texel span; all other cycles, including all blanking cycles, serve point queries (x,y → palette index), e.g. for ball/terrain collision. The block sits between the DrawX/DrawY generator and the field ROM, and feeds the field palette lookup.

---
 rtl/field_rom_scheduler_if.sv | 21 ++
 rtl/field_rom_scheduler.sv | 128 ++++++++++++
 tb/tb_field_rom_scheduler.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/field_rom_scheduler_if.sv
// Point-query request/response bus between game logic and the field ROM scheduler.
// The requester holds q_valid/q_x/q_y until q_ready; responses arrive as r_valid strobes.
interface field_rom_scheduler_if;
  logic       q_valid;
  logic [7:0] q_x;
  logic [6:0] q_y;
  logic       q_ready;
  logic       r_valid;
  logic [3:0] r_data;
  logic       r_err;

  modport master (
    output q_valid, q_x, q_y,
    input  q_ready, r_valid, r_data, r_err
  );

  modport slave (
    input  q_valid, q_x, q_y,
    output q_ready, r_valid, r_data, r_err
  );
endinterface

// File: rtl/field_rom_scheduler.sv
// Time-slot arbiter for the single-port 160x120x4 field ROM: one display fetch per
// 4-pixel span while visible, point queries on every other cycle, 2-cycle tagged pipeline.
module field_rom_scheduler (
  input  logic                  vga_clk,
  input  logic                  reset_n,
  input  logic [9:0]            DrawX,
  input  logic [9:0]            DrawY,
  input  logic                  blank,
  field_rom_scheduler_if.slave  q_if,
  output logic [14:0]           rom_addr,
  input  logic [3:0]            rom_q,
  output logic [3:0]            pix_index,
  output logic                  pix_valid
);

  localparam int unsigned ROM_W = 160;
  localparam int unsigned ROM_H = 120;
  localparam int unsigned AW    = 15;
  localparam int unsigned DW    = 4;

  localparam logic [1:0] TAG_NONE = 2'd0;
  localparam logic [1:0] TAG_DISP = 2'd1;
  localparam logic [1:0] TAG_QRY  = 2'd2;
  localparam logic [1:0] TAG_QERR = 2'd3;

  // row * 160 as two shifts; largest in-range result is 119*160 = 19040
  function automatic logic [AW-1:0] row_base(input logic [7:0] row);
    row_base = (AW'(row) << 7) + (AW'(row) << 5);
  endfunction

  logic          disp_slot_c;
  logic          q_acc_c;
  logic          q_in_range_c;
  logic [AW-1:0] disp_addr_c;
  logic [AW-1:0] qry_addr_c;
  logic          unused_draw_y_c;

  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic [1:0]    tag1_q, tag1_d;
  logic [DW-1:0] hold_q, hold_d;
  logic          blank_d1_q;
  logic          pix_valid_q;
  logic [DW-1:0] pix_index_q, pix_index_d;
  logic          r_valid_q, r_valid_d;
  logic [DW-1:0] r_data_q, r_data_d;
  logic          r_err_q, r_err_d;

  // Slot classification and candidate addresses
  assign disp_slot_c     = blank & (DrawX[1:0] == 2'b00);
  assign q_if.q_ready    = reset_n & ~disp_slot_c;
  assign q_acc_c         = q_if.q_valid & q_if.q_ready;
  assign q_in_range_c    = (q_if.q_x < 8'(ROM_W)) & (q_if.q_y < 7'(ROM_H));
  assign disp_addr_c     = AW'(DrawX[9:2]) + row_base(DrawY[9:2]);
  assign qry_addr_c      = AW'(q_if.q_x) + row_base(8'(q_if.q_y));
  assign unused_draw_y_c = ^DrawY[1:0];

  // Stage 1: pick the slot owner; out-of-range queries leave the address alone
  always_comb begin
    rom_addr_d = rom_addr_q;
    tag1_d     = TAG_NONE;
    if (disp_slot_c) begin
      rom_addr_d = disp_addr_c;
      tag1_d     = TAG_DISP;
    end else if (q_acc_c) begin
      if (q_in_range_c) begin
        rom_addr_d = qry_addr_c;
        tag1_d     = TAG_QRY;
      end else begin
        tag1_d     = TAG_QERR;
      end
    end
  end

  // Stage 2: route rom_q by tag into the pixel hold register or the response port
  always_comb begin
    hold_d    = hold_q;
    r_valid_d = 1'b0;
    r_data_d  = r_data_q;
    r_err_d   = r_err_q;
    case (tag1_q)
      TAG_DISP: hold_d = rom_q;
      TAG_QRY: begin
        r_valid_d = 1'b1;
        r_data_d  = rom_q;
        r_err_d   = 1'b0;
      end
      TAG_QERR: begin
        r_valid_d = 1'b1;
        r_data_d  = '0;
        r_err_d   = 1'b1;
      end
      default: ;
    endcase
    pix_index_d = blank_d1_q ? hold_d : '0;
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr_q  <= '0;
      tag1_q      <= TAG_NONE;
      hold_q      <= '0;
      blank_d1_q  <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_index_q <= '0;
      r_valid_q   <= 1'b0;
      r_data_q    <= '0;
      r_err_q     <= 1'b0;
    end else begin
      rom_addr_q  <= rom_addr_d;
      tag1_q      <= tag1_d;
      hold_q      <= hold_d;
      blank_d1_q  <= blank;
      pix_valid_q <= blank_d1_q;
      pix_index_q <= pix_index_d;
      r_valid_q   <= r_valid_d;
      r_data_q    <= r_data_d;
      r_err_q     <= r_err_d;
    end
  end

  assign rom_addr     = rom_addr_q;
  assign pix_index    = pix_index_q;
  assign pix_valid    = pix_valid_q;
  assign q_if.r_valid = r_valid_q;
  assign q_if.r_data  = r_data_q;
  assign q_if.r_err   = r_err_q;

endmodule

// File: tb/tb_field_rom_scheduler.sv
// Randomized and directed check of field_rom_scheduler against a cycle-level
// reference model: expected ROM address, pixel and query responses per cycle.
module tb_field_rom_scheduler;

  logic        vga_clk = 1'b0;
  logic        reset_n;
  logic [9:0]  DrawX, DrawY;
  logic        blank;
  logic [14:0] rom_addr;
  logic [3:0]  rom_q;
  logic [3:0]  pix_index;
  logic        pix_valid;

  field_rom_scheduler_if q_if();

  field_rom_scheduler dut (
    .vga_clk   (vga_clk),
    .reset_n   (reset_n),
    .DrawX     (DrawX),
    .DrawY     (DrawY),
    .blank     (blank),
    .q_if      (q_if),
    .rom_addr  (rom_addr),
    .rom_q     (rom_q),
    .pix_index (pix_index),
    .pix_valid (pix_valid)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic logic [3:0] rom_val(input int a);
    return 4'(a & 15);
  endfunction

  // Falling-edge ROM: data valid at the next rising edge
  always @(negedge vga_clk) rom_q <= rom_val(int'(rom_addr));

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference state: expected rom_addr now, last display texel, and a 4-entry
  // ring of expected outputs indexed by cycle number.
  int   m_addr;
  int   m_last;
  logic e_rv [4];
  logic e_re [4];
  logic e_pv [4];
  int   e_rd [4];
  int   e_pi [4];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_addr = 0;
    m_last = 0;
    for (int i = 0; i < 4; i++) begin
      e_rv[i] = 1'b0; e_re[i] = 1'b0; e_pv[i] = 1'b0;
      e_rd[i] = 0;    e_pi[i] = 0;
    end
  endtask

  // One clock cycle: check registered outputs, drive inputs, check q_ready, advance model
  task automatic cycle(input logic b, input int dx, input int dy,
                       input logic qv, input int qx, input int qy, output logic acc);
    int   s, n2;
    logic disp, inr;
    s  = cyc % 4;
    n2 = (cyc + 2) % 4;
    check_eq("rom_addr", 32'(rom_addr), 32'(m_addr));
    check_eq("pix_valid", 32'(pix_valid), 32'(e_pv[s]));
    check_eq("pix_index", 32'(pix_index), 32'(e_pi[s]));
    check_eq("r_valid", 32'(q_if.r_valid), 32'(e_rv[s]));
    if (e_rv[s]) begin
      check_eq("r_data", 32'(q_if.r_data), 32'(e_rd[s]));
      check_eq("r_err", 32'(q_if.r_err), 32'(e_re[s]));
    end
    blank       = b;
    DrawX       = 10'(dx);
    DrawY       = 10'(dy);
    q_if.q_valid = qv;
    q_if.q_x    = 8'(qx);
    q_if.q_y    = 7'(qy);
    #1;
    disp = b && (dx % 4 == 0);
    check_eq("q_ready", 32'(q_if.q_ready), 32'(!disp));
    acc = qv && !disp;
    inr = (qx < 160) && (qy < 120);
    e_rv[n2] = 1'b0; e_re[n2] = 1'b0; e_rd[n2] = 0;
    if (disp) begin
      m_addr = dx / 4 + (dy / 4) * 160;
      m_last = int'(rom_val(m_addr));
    end else if (acc) begin
      e_rv[n2] = 1'b1;
      if (inr) begin
        m_addr   = qx + qy * 160;
        e_rd[n2] = int'(rom_val(m_addr));
      end else begin
        e_re[n2] = 1'b1;
      end
    end
    e_pv[n2] = b;
    e_pi[n2] = b ? m_last : 0;
    @(posedge vga_clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) cycle(1'b0, 700, 500, 1'b0, 0, 0, a);
  endtask

  // Assert reset mid-cycle, check everything clears at once, release after two edges
  task automatic do_reset();
    reset_n      = 1'b0;
    blank        = 1'b0;
    q_if.q_valid = 1'b1;
    #1;
    check_eq("rst_rom_addr", 32'(rom_addr), 32'd0);
    check_eq("rst_pix_index", 32'(pix_index), 32'd0);
    check_eq("rst_pix_valid", 32'(pix_valid), 32'd0);
    check_eq("rst_r_valid", 32'(q_if.r_valid), 32'd0);
    check_eq("rst_r_data", 32'(q_if.r_data), 32'd0);
    check_eq("rst_r_err", 32'(q_if.r_err), 32'd0);
    check_eq("rst_q_ready", 32'(q_if.q_ready), 32'd0);
    @(posedge vga_clk);
    @(posedge vga_clk);
    #1;
    reset_n      = 1'b1;
    q_if.q_valid = 1'b0;
    model_reset();
  endtask

  initial begin
    logic acc, hv;
    int   hx, hy, dx, dy;
    reset_n = 1'b1;
    blank = 1'b0; DrawX = '0; DrawY = '0;
    q_if.q_valid = 1'b0; q_if.q_x = '0; q_if.q_y = '0;
    @(posedge vga_clk);
    #1;
    do_reset();
    idle(2);

    // Display fetch on row 8: spans 320 and 321
    for (int x = 0; x < 12; x++) begin
      cycle(1'b1, x, 8, 1'b0, 0, 0, acc);
      if (x == 0) check_eq("disp_addr_x0", 32'(rom_addr), 32'd320);
      if (x == 4) check_eq("disp_addr_x4", 32'(rom_addr), 32'd321);
    end
    idle(3);

    // Corner query during blanking
    cycle(1'b0, 700, 10, 1'b1, 159, 119, acc);
    check_eq("q_corner_addr", 32'(rom_addr), 32'd19199);
    idle(3);

    // Query held across a display slot
    hv = 1'b1;
    for (int x = 0; x < 8; x++) begin
      cycle(1'b1, x, 16, hv, 5, 7, acc);
      if (acc) hv = 1'b0;
    end
    idle(3);

    // Back-to-back queries in blanking
    for (int i = 0; i < 6; i++) cycle(1'b0, 640 + i, 30, 1'b1, 20 * i + 3, 17 * i + 1, acc);
    idle(3);

    // Out-of-range query
    cycle(1'b0, 700, 40, 1'b1, 160, 0, acc);
    idle(3);

    // Reset with a query in flight, then a fresh display fetch
    cycle(1'b0, 700, 20, 1'b1, 10, 10, acc);
    do_reset();
    idle(3);
    for (int x = 0; x < 8; x++) cycle(1'b1, x, 4, 1'b0, 0, 0, acc);
    idle(3);

    // Random raster segments with random queries and occasional blank glitches
    hv = 1'b0; hx = 0; hy = 0;
    for (int seg = 0; seg < 60; seg++) begin
      dy = int'($urandom_range(0, 524));
      dx = int'($urandom_range(0, 799));
      for (int k = 0; k < 40; k++) begin
        if (!hv && ($urandom_range(0, 9) < 6)) begin
          hv = 1'b1;
          hx = int'($urandom_range(0, 169));
          hy = int'($urandom_range(0, 125));
        end
        cycle((dx < 640) && (dy < 480) && ($urandom_range(0, 15) != 0),
              dx, dy, hv, hx, hy, acc);
        if (acc) hv = 1'b0;
        dx++;
        if (dx == 800) begin
          dx = 0;
          dy = (dy + 1) % 525;
        end
      end
    end
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
